// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit: MEM pipeline stage with word-wide data memory.
module mem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_out,
  output logic [31:0] load_data_out,
  output logic        fault_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAST = 3'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, mem_to_reg_q, reg_write_q, fault_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q, load_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          is_mem, is_load, funct_ok, misalign, fault, legal_mem;
  logic          need_wait, final_wait, complete, mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, wdata, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_hi;

  assign idx       = alu_in[AW+1:2];
  assign unused_hi = ^alu_in[31:AW+2];
  assign rd_word   = mem_q[idx];

  // Simultaneous read and write requests are treated as a store.
  assign is_mem  = valid_in & (mem_read_in | mem_write_in);
  assign is_load = mem_read_in & ~mem_write_in;

  always_comb begin
    funct_ok = 1'b0;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
      3'b100, 3'b101:         funct_ok = is_load;
      default:                funct_ok = 1'b0;
    endcase
  end

  assign misalign   = ((funct3_in[1:0] == 2'b01) & alu_in[0]) |
                      ((funct3_in[1:0] == 2'b10) & (alu_in[1:0] != 2'b00));
  assign fault      = is_mem & (~funct_ok | misalign);
  assign legal_mem  = is_mem & ~fault;
  assign need_wait  = legal_mem & (WAIT_STATES != 0);
  assign final_wait = (state_q == S_WAIT) & (cnt_q == LAST);
  assign complete   = ((state_q == S_IDLE) & ~need_wait) | final_wait;
  // Gating with reset keeps a store from landing while reset is held across an edge.
  assign mem_we     = complete & legal_mem & mem_write_in & reset;
  assign stall_out  = reset & ((state_q == S_IDLE) ? need_wait : ~final_wait);

  always_comb begin
    byte_sel = rd_word[{alu_in[1:0], 3'b000} +: 8];
    half_sel = alu_in[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'h0;
    if (legal_mem && is_load) begin
      case (funct3_in)
        3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
        3'b010:  load_val = rd_word;
        3'b100:  load_val = {24'h0, byte_sel};
        3'b101:  load_val = {16'h0, half_sel};
        default: load_val = 32'h0;
      endcase
    end
  end

  always_comb begin
    wdata = rd_word;
    case (funct3_in)
      3'b000:  wdata[{alu_in[1:0], 3'b000} +: 8] = store_data_in[7:0];
      3'b001:  wdata[{alu_in[1], 4'b0000} +: 16] = store_data_in[15:0];
      default: wdata = store_data_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (need_wait) begin
        state_d = S_WAIT;
        cnt_d   = 3'd0;
      end
      S_WAIT: if (final_wait) state_d = S_IDLE;
              else            cnt_d   = cnt_q + 3'd1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      fault_q      <= 1'b0;
      rd_q         <= 5'd0;
      alu_q        <= 32'h0;
      load_q       <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete) begin
        valid_q      <= valid_in;
        mem_to_reg_q <= mem_to_reg_in;
        reg_write_q  <= valid_in & reg_write_in & ~fault;
        fault_q      <= fault;
        rd_q         <= rd_in;
        alu_q        <= alu_in;
        load_q       <= load_val;
      end else begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        fault_q     <= 1'b0;
        load_q      <= 32'h0;
      end
    end
  end

  // Data array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wdata;
  end

  assign valid_out      = valid_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign reg_write_out  = reg_write_q;
  assign rd_out         = rd_q;
  assign alu_out        = alu_q;
  assign load_data_out  = load_q;
  assign fault_out      = fault_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed scoreboard bench for mem_lsu (zero and three wait states).
module tb_mem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in[2], mem_read_in[2], mem_write_in[2], mem_to_reg_in[2], reg_write_in[2];
  logic [2:0]  funct3_in[2];
  logic [4:0]  rd_in[2];
  logic [31:0] alu_in[2], store_data_in[2];
  logic        stall_out[2], valid_out[2], mem_to_reg_out[2], reg_write_out[2], fault_out[2];
  logic [4:0]  rd_out[2];
  logic [31:0] alu_out[2], load_data_out[2];

  mem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .valid_in(valid_in[0]), .mem_read_in(mem_read_in[0]),
    .mem_write_in(mem_write_in[0]), .funct3_in(funct3_in[0]), .mem_to_reg_in(mem_to_reg_in[0]),
    .reg_write_in(reg_write_in[0]), .rd_in(rd_in[0]), .alu_in(alu_in[0]),
    .store_data_in(store_data_in[0]), .stall_out(stall_out[0]), .valid_out(valid_out[0]),
    .mem_to_reg_out(mem_to_reg_out[0]), .reg_write_out(reg_write_out[0]), .rd_out(rd_out[0]),
    .alu_out(alu_out[0]), .load_data_out(load_data_out[0]), .fault_out(fault_out[0]));

  mem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .valid_in(valid_in[1]), .mem_read_in(mem_read_in[1]),
    .mem_write_in(mem_write_in[1]), .funct3_in(funct3_in[1]), .mem_to_reg_in(mem_to_reg_in[1]),
    .reg_write_in(reg_write_in[1]), .rd_in(rd_in[1]), .alu_in(alu_in[1]),
    .store_data_in(store_data_in[1]), .stall_out(stall_out[1]), .valid_out(valid_out[1]),
    .mem_to_reg_out(mem_to_reg_out[1]), .reg_write_out(reg_write_out[1]), .rd_out(rd_out[1]),
    .alu_out(alu_out[1]), .load_data_out(load_data_out[1]), .fault_out(fault_out[1]));

  typedef struct {
    string       tag;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] load;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic rd_, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                       input logic m2r, input logic [4:0] rd);
    valid_in[d] = v; mem_read_in[d] = rd_; mem_write_in[d] = wr; funct3_in[d] = f3;
    alu_in[d] = addr; store_data_in[d] = sdata; reg_write_in[d] = rw;
    mem_to_reg_in[d] = m2r; rd_in[d] = rd;
  endtask

  task automatic issue(input int d, input string tag, input logic rd_, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] exp_load, input logic exp_fault, input int exp_stalls);
    exp_t e;
    int   stalls, cyc;
    bit   done;
    @(negedge clk);
    drive(d, 1'b1, rd_, wr, f3, addr, sdata, rw, m2r, rd);
    sb.push_back('{tag, rw & ~exp_fault, m2r, rd, addr, exp_load, exp_fault});
    #1;
    stalls = int'(stall_out[d]);
    cyc = 0;
    done = 0;
    while (!done && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out[d]) done = 1;
      else if (stall_out[d]) stalls++;
    end
    valid_in[d] = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 32'(cyc), 32'(exp_stalls + 1));
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_latency"}, 32'(cyc), 32'(exp_stalls + 1));
      chk({e.tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      chk({e.tag, "_load"}, load_data_out[d], e.load);
      chk({e.tag, "_fault"}, 32'(fault_out[d]), 32'(e.fault));
      chk({e.tag, "_rw"}, 32'(reg_write_out[d]), 32'(e.rw));
      chk({e.tag, "_m2r"}, 32'(mem_to_reg_out[d]), 32'(e.m2r));
      chk({e.tag, "_rd"}, 32'(rd_out[d]), 32'(e.rd));
      chk({e.tag, "_alu"}, alu_out[d], e.alu);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_valid"}, 32'(valid_out[d]), 32'h0);
    chk({tag, "_stall"}, 32'(stall_out[d]), 32'h0);
    chk({tag, "_rw"}, 32'(reg_write_out[d]), 32'h0);
    chk({tag, "_fault"}, 32'(fault_out[d]), 32'h0);
    chk({tag, "_alu"}, alu_out[d], 32'h0);
    chk({tag, "_rd"}, 32'(rd_out[d]), 32'h0);
    chk({tag, "_load"}, load_data_out[d], 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drive(d, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "reset_ws0");
    chk_zero(1, "reset_ws3");
    @(negedge clk);
    reset = 1'b1;

    // Zero wait states: word, byte and half accesses.
    issue(0, "sw_10",   0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0,        0, 0);
    issue(0, "lw_10",   1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    issue(0, "sb_11",   0, 1, 3'b000, 32'h11, 32'h12345680, 0, 0, 5'd0, 32'h0,        0, 0);
    issue(0, "lb_11",   1, 0, 3'b000, 32'h11, 32'h0,        1, 1, 5'd6, 32'hFFFFFF80, 0, 0);
    issue(0, "lbu_11",  1, 0, 3'b100, 32'h11, 32'h0,        1, 1, 5'd7, 32'h00000080, 0, 0);
    issue(0, "lw_10b",  1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd8, 32'hDEAD80EF, 0, 0);
    issue(0, "lh_12",   1, 0, 3'b001, 32'h12, 32'h0,        1, 1, 5'd9, 32'hFFFFDEAD, 0, 0);
    issue(0, "lhu_12",  1, 0, 3'b101, 32'h12, 32'h0,        1, 1, 5'd10, 32'h0000DEAD, 0, 0);
    issue(0, "sh_12",   0, 1, 3'b001, 32'h12, 32'hAAAA7FFF, 0, 0, 5'd0, 32'h0,        0, 0);
    issue(0, "lw_10c",  1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd11, 32'h7FFF80EF, 0, 0);
    issue(0, "alu_op",  0, 0, 3'b010, 32'h12345678, 32'h0,  1, 0, 5'd12, 32'h0,       0, 0);
    issue(0, "ld_f011", 1, 0, 3'b011, 32'h0,  32'h0,        1, 1, 5'd13, 32'h0,       1, 0);
    issue(0, "sb_f100", 0, 1, 3'b100, 32'h10, 32'h11111111, 0, 0, 5'd0, 32'h0,        1, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("idle_valid", 32'(valid_out[0]), 32'h0);
    chk("idle_fault", 32'(fault_out[0]), 32'h0);
    chk("idle_rw", 32'(reg_write_out[0]), 32'h0);
    issue(0, "lw_10d",  1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd14, 32'h7FFF80EF, 0, 0);
    issue(0, "rw_both", 1, 1, 3'b010, 32'h8,  32'h00000055, 1, 0, 5'd15, 32'h0,       0, 0);
    issue(0, "lw_08",   1, 0, 3'b010, 32'h8,  32'h0,        1, 1, 5'd16, 32'h00000055, 0, 0);
    issue(0, "sw_400",  0, 1, 3'b010, 32'h400, 32'h00001234, 0, 0, 5'd0, 32'h0,      0, 0);
    issue(0, "lw_00",   1, 0, 3'b010, 32'h0,  32'h0,        1, 1, 5'd17, 32'h00001234, 0, 0);

    // Three wait states: stalls, pass-through after a load, faults skip waiting.
    issue(1, "w_sw_10",  0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 5'd0, 32'h0,        0, 3);
    issue(1, "w_lw_10",  1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd3, 32'hCAFEF00D, 0, 3);
    issue(1, "w_alu_5",  0, 0, 3'b000, 32'h5,  32'h0,        1, 0, 5'd4, 32'h0,        0, 0);
    issue(1, "w_lw_12",  1, 0, 3'b010, 32'h12, 32'h0,        1, 1, 5'd5, 32'h0,        1, 0);
    issue(1, "w_sh_13",  0, 1, 3'b001, 32'h13, 32'hFFFFFFFF, 0, 0, 5'd0, 32'h0,        1, 0);
    issue(1, "w_lw_10b", 1, 0, 3'b010, 32'h10, 32'h0,        1, 1, 5'd6, 32'hCAFEF00D, 0, 3);
    issue(1, "w_sw_20",  0, 1, 3'b010, 32'h20, 32'h0,        0, 0, 5'd0, 32'h0,        0, 3);

    // Reset asserted during the first WAIT cycle of a store.
    @(negedge clk);
    drive(1, 1, 0, 1, 3'b010, 32'h20, 32'hFFFFFFFF, 0, 0, 5'd0);
    #1;
    chk("abort_stall_pre", 32'(stall_out[1]), 32'h1);
    @(posedge clk);
    #1;
    chk("abort_stall_wait", 32'(stall_out[1]), 32'h1);
    reset = 1'b0;
    #1;
    chk_zero(1, "abort");
    valid_in[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(1, "w_lw_20",  1, 0, 3'b010, 32'h20, 32'h0,        1, 1, 5'd7, 32'h0,        0, 3);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
